// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pulls words one at a time from a FIFO with
// stop-and-wait handshaking and forwards them through a 2-entry skid buffer.
module fifo_rd_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [3:0]            burst_len,
   input  logic                  fifo_empty,
   input  logic                  fifo_rd_ack,
   input  logic                  fifo_rd_err,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  busy,
   output logic                  done,
   output logic [3:0]            word_cnt,
   output logic [7:0]            err_cnt
);

   localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            word_cnt_q, word_cnt_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  err_inc;
   logic                  push, pop;

   logic [DATA_WIDTH-1:0] buf_q [2];
   logic                  buf_wr_q, buf_rd_q;
   logic [1:0]            buf_cnt_q, buf_cnt_d;

   assign m_valid  = (buf_cnt_q != 2'd0);
   assign m_data   = buf_q[buf_rd_q];
   assign pop      = m_valid && m_ready;
   assign busy     = (state_q != IDLE);
   assign word_cnt = word_cnt_q;
   assign err_cnt  = err_cnt_q;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      tmo_d      = tmo_q;
      err_inc    = 1'b0;
      push       = 1'b0;
      fifo_rd_en = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (burst_len == 4'd0) begin
                  word_cnt_d = 4'd0;
                  state_d    = DONE;
               end else if (burst_len <= 4'd8) begin
                  len_d      = burst_len;
                  word_cnt_d = 4'd0;
                  state_d    = ISSUE;
               end else begin
                  err_inc = 1'b1;
               end
            end
         end
         ISSUE: begin
            tmo_d = '0;
            // Only issue when the buffer can absorb the reply even if nothing pops.
            if (!fifo_empty && (buf_cnt_q <= 2'd1)) begin
               fifo_rd_en = 1'b1;
               state_d    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (fifo_rd_ack) begin
               push       = 1'b1;
               word_cnt_d = word_cnt_q + 4'd1;
               state_d    = (word_cnt_d == len_q) ? DRAIN : ISSUE;
            end else if (fifo_rd_err) begin
               err_inc = 1'b1;
               state_d = ISSUE;
            end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
               err_inc = 1'b1;
               state_d = ISSUE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         DRAIN: begin
            if (buf_cnt_q == 2'd0) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      buf_cnt_d = buf_cnt_q;
      if (push && !pop)      buf_cnt_d = buf_cnt_q + 2'd1;
      else if (pop && !push) buf_cnt_d = buf_cnt_q - 2'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         err_cnt_q  <= '0;
         tmo_q      <= '0;
         buf_wr_q   <= 1'b0;
         buf_rd_q   <= 1'b0;
         buf_cnt_q  <= '0;
         for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         err_cnt_q  <= err_cnt_d;
         tmo_q      <= tmo_d;
         buf_cnt_q  <= buf_cnt_d;
         if (push) begin
            buf_q[buf_wr_q] <= fifo_dout;
            buf_wr_q        <= ~buf_wr_q;
         end
         if (pop) buf_rd_q <= ~buf_rd_q;
      end
   end

endmodule
